// File: rtl/dlx_pkg.sv
`timescale 1ns/1ps
// Shared types and width helpers for the DLX fetch front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   XLEN         - architectural word width, upper bound for ADDR_W / INSTR_W
//   INSTR_BYTES  - PC increment between sequential fetches
//   fetch_slot_t - one reservation-queue entry {pc, data, filled}
//   ptr_w/cnt_w  - pointer and counter widths derived from the queue depth
package dlx_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
        logic            filled;
    } fetch_slot_t;

    // Queue pointers carry one extra wrap bit so full and empty differ.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Wide enough to hold any value 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dlx_fetch_slot_queue.sv
`timescale 1ns/1ps
// In-order reservation queue: slots allocated at request, filled at response, popped by ID.
// Latency: a fill is visible at the head one cycle after i_fill.
// Backpressure: caller must not allocate when o_used == DEPTH nor pop an invalid head.
//
// Ports:
//   clk, reset            - clock, async active-high reset
//   i_alloc, i_alloc_pc   - reserve the next slot for a request at this PC
//   i_fill, i_fill_data   - write the oldest unfilled slot
//   i_pop                 - retire the head slot
//   i_flush               - drop everything (dominates alloc/fill/pop)
//   o_used, o_pending     - alloc-rd and alloc-fill distances
//   o_head_*              - head slot contents, valid once filled
module dlx_fetch_slot_queue
    import dlx_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4,
    localparam int PW     = ptr_w(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_alloc,
    input  logic [ADDR_W-1:0]  i_alloc_pc,
    input  logic               i_fill,
    input  logic [INSTR_W-1:0] i_fill_data,
    input  logic               i_pop,
    input  logic               i_flush,
    output logic [PW-1:0]      o_used,
    output logic [PW-1:0]      o_pending,
    output logic               o_head_valid,
    output logic [ADDR_W-1:0]  o_head_pc,
    output logic [INSTR_W-1:0] o_head_data
);

    localparam int IW = PW - 1;

    fetch_slot_t   r_slots [DEPTH];
    logic [PW-1:0] r_alloc_ptr;
    logic [PW-1:0] r_fill_ptr;
    logic [PW-1:0] r_rd_ptr;

    logic [IW-1:0] w_alloc_idx;
    logic [IW-1:0] w_fill_idx;
    logic [IW-1:0] w_rd_idx;

    assign w_alloc_idx = r_alloc_ptr[IW-1:0];
    assign w_fill_idx  = r_fill_ptr[IW-1:0];
    assign w_rd_idx    = r_rd_ptr[IW-1:0];

    // Alloc and fill never target the same slot: a fill needs an outstanding
    // request, and alloc needs a free slot, so fill_ptr != alloc_ptr mod DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i] <= '0;
            end
        end else if (i_flush) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i].filled <= 1'b0;
            end
        end else begin
            if (i_alloc) begin
                r_slots[w_alloc_idx].pc     <= XLEN'(i_alloc_pc);
                r_slots[w_alloc_idx].filled <= 1'b0;
                r_alloc_ptr                 <= r_alloc_ptr + PW'(1);
            end
            if (i_fill) begin
                r_slots[w_fill_idx].data   <= XLEN'(i_fill_data);
                r_slots[w_fill_idx].filled <= 1'b1;
                r_fill_ptr                 <= r_fill_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    assign o_used       = r_alloc_ptr - r_rd_ptr;
    assign o_pending    = r_alloc_ptr - r_fill_ptr;
    assign o_head_valid = (r_rd_ptr != r_alloc_ptr) && r_slots[w_rd_idx].filled;
    assign o_head_pc    = ADDR_W'(r_slots[w_rd_idx].pc);
    assign o_head_data  = INSTR_W'(r_slots[w_rd_idx].data);

endmodule

// File: rtl/dlx_fetch_unit.sv
`timescale 1ns/1ps
// DLX instruction fetch: pipelined ROM requests, in-order reservation queue, redirect flush.
// Latency: ROM response in cycle N gives instr_valid in N+1 (R+2 for a 1-cycle ROM).
// Backpressure: i_req drops when DEPTH fetches are queued or in flight; instr_ready stalls the head.
//
// Ports:
//   clk, reset               - clock, async active-high reset
//   i_address, i_req         - ROM request (address is the current PC)
//   i_data_valid, i_data_read- ROM response, returned in request order
//   pc_cmd_ID/pc_in_ID       - redirect from ID
//   pc_cmd_EX/pc_in_EX       - redirect from EX (wins over ID)
//   instr_valid/instr/instr_pc/instr_ready - valid/ready delivery to ID
module dlx_fetch_unit
    import dlx_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  i_address,
    output logic               i_req,
    input  logic               i_data_valid,
    input  logic [INSTR_W-1:0] i_data_read,
    input  logic               pc_cmd_ID,
    input  logic [ADDR_W-1:0]  pc_in_ID,
    input  logic               pc_cmd_EX,
    input  logic [ADDR_W-1:0]  pc_in_EX,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam int SW = PW + 1;

    logic [ADDR_W-1:0] r_pc;
    logic [CW-1:0]     r_discard_cnt;

    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;
    logic              w_issue;
    logic              w_drop;
    logic              w_fill;
    logic              w_pop;
    logic              w_head_valid;
    logic [PW-1:0]     w_used;
    logic [PW-1:0]     w_pending;
    logic [SW-1:0]     w_inflight;
    logic [SW-1:0]     w_discard_nxt;
    logic [SW-1:0]     w_discard_sat;

    assign w_redirect = pc_cmd_EX | pc_cmd_ID;
    assign w_target   = pc_cmd_EX ? pc_in_EX : pc_in_ID;

    // Occupancy counts slots from rd_ptr, so a pop only frees issue next cycle.
    assign w_issue = !reset && !w_redirect && (w_used < PW'(DEPTH));

    // Stale responses (from before a redirect) are always consumed first.
    assign w_drop = i_data_valid && (r_discard_cnt != '0);
    assign w_fill = i_data_valid && (r_discard_cnt == '0) && (w_pending != '0) && !w_redirect;
    assign w_pop  = w_head_valid && instr_ready && !w_redirect;

    // Everything already requested and not yet returned becomes stale on a
    // redirect; a response arriving in the redirect cycle itself is one of them.
    assign w_inflight    = SW'(r_discard_cnt) + SW'(w_pending);
    assign w_discard_nxt = (i_data_valid && (w_inflight != '0)) ? (w_inflight - SW'(1)) : w_inflight;
    assign w_discard_sat = (w_discard_nxt > SW'(DEPTH)) ? SW'(DEPTH) : w_discard_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_discard_cnt <= '0;
        end else begin
            if (w_redirect) begin
                r_pc          <= w_target;
                r_discard_cnt <= CW'(w_discard_sat);
            end else begin
                if (w_issue) begin
                    r_pc <= r_pc + ADDR_W'(INSTR_BYTES);
                end
                if (w_drop) begin
                    r_discard_cnt <= r_discard_cnt - CW'(1);
                end
            end
        end
    end

    dlx_fetch_slot_queue #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .i_alloc      (w_issue),
        .i_alloc_pc   (r_pc),
        .i_fill       (w_fill),
        .i_fill_data  (i_data_read),
        .i_pop        (w_pop),
        .i_flush      (w_redirect),
        .o_used       (w_used),
        .o_pending    (w_pending),
        .o_head_valid (w_head_valid),
        .o_head_pc    (instr_pc),
        .o_head_data  (instr)
    );

    assign i_req       = w_issue;
    assign i_address   = r_pc;
    assign instr_valid = !reset && w_head_valid;

    // A ROM response with nothing outstanding is a protocol error; it is ignored.
    a_no_orphan_response : assert property (@(posedge clk) disable iff (reset)
        i_data_valid |-> ((r_discard_cnt != '0) || (w_pending != '0)));

endmodule

// File: tb/tb_dlx_fetch_unit.sv
`timescale 1ns/1ps
module tb_dlx_fetch_unit;

    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 4;

    logic          clk          = 1'b0;
    logic          reset        = 1'b1;
    logic [AW-1:0] i_address;
    logic          i_req;
    logic          i_data_valid = 1'b0;
    logic [IW-1:0] i_data_read  = '0;
    logic          pc_cmd_ID    = 1'b0;
    logic [AW-1:0] pc_in_ID     = '0;
    logic          pc_cmd_EX    = 1'b0;
    logic [AW-1:0] pc_in_EX     = '0;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready  = 1'b1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dlx_fetch_unit #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_address    (i_address),
        .i_req        (i_req),
        .i_data_valid (i_data_valid),
        .i_data_read  (i_data_read),
        .pc_cmd_ID    (pc_cmd_ID),
        .pc_in_ID     (pc_in_ID),
        .pc_cmd_EX    (pc_cmd_EX),
        .pc_in_EX     (pc_in_EX),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready)
    );

    // ROM model: fixed latency rom_lat, data = ~address. Requests are captured
    // at the edge that ends their cycle; the response is driven for the whole
    // cycle rom_lat cycles after the request cycle.
    logic [31:0] rq_addr [$];
    int          rq_due  [$];
    int          cyc     = 0;
    int          rom_lat = 1;
    int          nreq    = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rq_addr.delete();
            rq_due.delete();
            cyc          = 0;
            nreq         = 0;
            i_data_valid = 1'b0;
            i_data_read  = '0;
        end else begin
            if (i_req) begin
                rq_addr.push_back(i_address);
                rq_due.push_back(cyc + rom_lat);
                nreq++;
            end
            #1;
            cyc++;
            i_data_valid = 1'b0;
            if (rq_due.size() > 0 && rq_due[0] == cyc) begin
                i_data_valid = 1'b1;
                i_data_read  = ~rq_addr[0];
                void'(rq_addr.pop_front());
                void'(rq_due.pop_front());
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    // Pulse reset for two edges; returns at the start of post-reset cycle 0.
    task automatic restart(input int lat);
        @(posedge clk);
        #2;
        reset   = 1'b1;
        rom_lat = lat;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pc;

        // ---------------- reset state, then sequential fetch (1-cycle ROM)
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req",     32'(i_req),             32'd0);
        chk("rst_addr",    i_address,              32'h100);
        chk("rst_vld",     32'(instr_valid),       32'd0);
        chk("rst_discard", 32'(dut.r_discard_cnt), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("seq_req0",  32'(i_req),       32'd1);
        chk("seq_addr0", i_address,        32'h100);
        chk("seq_vld0",  32'(instr_valid), 32'd0);
        nxt();
        @(negedge clk);
        chk("seq_addr1", i_address,        32'h104);
        chk("seq_vld1",  32'(instr_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            nxt();
            @(negedge clk);
            exp_pc = 32'h100 + 32'(4 * k);
            chk("seq_vld",   32'(instr_valid), 32'd1);
            chk("seq_pc",    instr_pc,         exp_pc);
            chk("seq_instr", instr,            ~exp_pc);
            chk("seq_addr",  i_address,        exp_pc + 32'h8);
        end

        // ---------------- backpressure: queue fills after exactly DEPTH requests
        instr_ready = 1'b0;
        restart(1);
        repeat (4) nxt();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("full_req",  32'(i_req),       32'd0);
            chk("full_vld",  32'(instr_valid), 32'd1);
            chk("full_pc",   instr_pc,         32'h100);
            chk("full_addr", i_address,        32'h110);
            nxt();
        end
        chk("full_nreq", 32'(nreq), 32'd4);
        instr_ready = 1'b1;
        @(negedge clk);
        chk("rel_req_same_cycle", 32'(i_req), 32'd0);
        chk("rel_pc0",            instr_pc,   32'h100);
        nxt();
        @(negedge clk);
        chk("rel_req_resume", 32'(i_req), 32'd1);
        chk("rel_addr",       i_address,  32'h110);
        chk("rel_pc1",        instr_pc,   32'h104);
        for (int k = 2; k < 5; k++) begin
            nxt();
            @(negedge clk);
            exp_pc = 32'h100 + 32'(4 * k);
            chk("rel_vld", 32'(instr_valid), 32'd1);
            chk("rel_pc",  instr_pc,         exp_pc);
        end

        // ---------------- EX redirect with 3 stale responses in flight (3-cycle ROM)
        restart(3);
        repeat (3) nxt();
        pc_cmd_EX = 1'b1;
        pc_in_EX  = 32'h400;
        @(negedge clk);
        chk("ex_req_redirect_cycle", 32'(i_req), 32'd0);
        nxt();
        pc_cmd_EX = 1'b0;
        @(negedge clk);
        chk("ex_req",      32'(i_req),             32'd1);
        chk("ex_addr",     i_address,              32'h400);
        chk("ex_vld4",     32'(instr_valid),       32'd0);
        chk("ex_discard2", 32'(dut.r_discard_cnt), 32'd2);
        nxt();
        @(negedge clk);
        chk("ex_vld5",     32'(instr_valid),       32'd0);
        chk("ex_discard1", 32'(dut.r_discard_cnt), 32'd1);
        nxt();
        @(negedge clk);
        chk("ex_vld6",     32'(instr_valid),       32'd0);
        chk("ex_discard0", 32'(dut.r_discard_cnt), 32'd0);
        nxt();
        @(negedge clk);
        chk("ex_vld7", 32'(instr_valid), 32'd0);
        nxt();
        @(negedge clk);
        chk("ex_vld8",  32'(instr_valid), 32'd1);
        chk("ex_pc",    instr_pc,         32'h400);
        chk("ex_instr", instr,            ~32'h400);

        // ---------------- simultaneous ID and EX redirect: EX wins
        restart(1);
        repeat (2) nxt();
        pc_cmd_ID = 1'b1;
        pc_in_ID  = 32'h200;
        pc_cmd_EX = 1'b1;
        pc_in_EX  = 32'h300;
        @(negedge clk);
        chk("prio_req_redirect_cycle", 32'(i_req), 32'd0);
        nxt();
        pc_cmd_ID = 1'b0;
        pc_cmd_EX = 1'b0;
        @(negedge clk);
        chk("prio_req",     32'(i_req),             32'd1);
        chk("prio_addr",    i_address,              32'h300);
        chk("prio_vld3",    32'(instr_valid),       32'd0);
        chk("prio_discard", 32'(dut.r_discard_cnt), 32'd0);
        nxt();
        @(negedge clk);
        chk("prio_vld4", 32'(instr_valid), 32'd0);
        nxt();
        @(negedge clk);
        chk("prio_vld5", 32'(instr_valid), 32'd1);
        chk("prio_pc",   instr_pc,         32'h300);

        // ---------------- back-to-back ID redirects, 2-cycle ROM
        restart(2);
        repeat (2) nxt();
        pc_cmd_ID = 1'b1;
        pc_in_ID  = 32'h200;
        nxt();
        pc_in_ID = 32'h300;
        @(negedge clk);
        chk("b2b_req3",  32'(i_req),       32'd0);
        chk("b2b_addr3", i_address,        32'h200);
        chk("b2b_vld3",  32'(instr_valid), 32'd0);
        nxt();
        pc_cmd_ID = 1'b0;
        @(negedge clk);
        chk("b2b_req4",  32'(i_req),       32'd1);
        chk("b2b_addr4", i_address,        32'h300);
        chk("b2b_vld4",  32'(instr_valid), 32'd0);
        nxt();
        @(negedge clk);
        chk("b2b_vld5", 32'(instr_valid), 32'd0);
        nxt();
        @(negedge clk);
        chk("b2b_vld6", 32'(instr_valid), 32'd0);
        nxt();
        @(negedge clk);
        chk("b2b_vld7",  32'(instr_valid), 32'd1);
        chk("b2b_pc",    instr_pc,         32'h300);
        chk("b2b_instr", instr,            ~32'h300);

        // ---------------- asynchronous reset mid-burst
        restart(1);
        repeat (3) nxt();
        @(negedge clk);
        chk("ar_pre_req", 32'(i_req),       32'd1);
        chk("ar_pre_vld", 32'(instr_valid), 32'd1);
        chk("ar_pre_pc",  instr_pc,         32'h104);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_req",     32'(i_req),             32'd0);
        chk("ar_vld",     32'(instr_valid),       32'd0);
        chk("ar_addr",    i_address,              32'h100);
        chk("ar_discard", 32'(dut.r_discard_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("ar_restart_req",  32'(i_req), 32'd1);
        chk("ar_restart_addr", i_address,  32'h100);
        repeat (2) nxt();
        @(negedge clk);
        chk("ar_restart_vld", 32'(instr_valid), 32'd1);
        chk("ar_restart_pc",  instr_pc,         32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dlx_fetch_unit.md
# dlx_fetch_unit

Parametrised instruction-fetch front end for the pipelined DLX core, replacing the single-register PC stage. Issues in-order requests to the instruction ROM with up to DEPTH outstanding, tolerates variable ROM latency via `i_data_valid`, and buffers returned words with their PCs in a reservation queue. Delivers instructions to ID through a valid/ready handshake and accepts redirects from ID and EX, which take priority.

## Interface
- `ADDR_W`, default 32: PC / ROM address width.
- `INSTR_W`, default 32: instruction width.
- `DEPTH`, default 4: queue slots, which is also the maximum outstanding plus buffered fetches. Must be a power of two and ≥2.
- `RESET_PC`, default 0: first fetch address.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `i_address` out ADDR_W: ROM request address.
- `i_req` out 1: request issued this cycle.
- `i_data_valid` in 1: ROM response valid, in request order.
- `i_data_read` in INSTR_W: ROM response data.
- `pc_cmd_ID` in 1: redirect from ID.
- `pc_in_ID` in ADDR_W: target from ID.
- `pc_cmd_EX` in 1: redirect from EX.
- `pc_in_EX` in ADDR_W: target from EX.
- `instr_valid` out 1: head instruction available.
- `instr` out INSTR_W: head instruction.
- `instr_pc` out ADDR_W: PC of head instruction.
- `instr_ready` in 1: ID accepts head.

## Operation
- **State**
  - `pc` register.
  - Queue of DEPTH slots {pc, data, filled}.
  - Pointers: `alloc_ptr`, `fill_ptr`, `rd_ptr`, each clog2(DEPTH)+1 bits with a wrap bit.
  - `discard_cnt`, clog2(DEPTH+1) bits.
- **Issue**
  - `i_req = !reset && !redirect && (alloc_ptr - rd_ptr) < DEPTH`.
  - `i_address = pc`.
  - On issue: allocate slot at `alloc_ptr` with slot.pc = `pc`, filled = 0; then `pc += 4` (modulo 2^ADDR_W), `alloc_ptr++`.
- **Response**
  - If `i_data_valid && discard_cnt != 0`: drop the data, `discard_cnt--`.
  - Else if `i_data_valid`: write data to slot `fill_ptr`, set filled, `fill_ptr++`.
  - A response with no request outstanding is a protocol error. It is ignored and flagged by an assertion.
- **Dequeue**
  - `instr_valid = (rd_ptr != alloc_ptr) && slot[rd_ptr].filled`.
  - Handshake `instr_valid && instr_ready` pops the head (`rd_ptr++`).
- **Redirect** (`redirect = pc_cmd_EX | pc_cmd_ID`)
  - Target is `pc_in_EX` if `pc_cmd_EX`, else `pc_in_ID`. EX wins when both are asserted.
  - At the edge: `pc <= target`; all pointers reset to 0; all filled bits cleared.
  - `discard_cnt <= discard_cnt + (alloc_ptr - fill_ptr) - (i_data_valid ? 1 : 0)`. Unfilled requests still in flight become stale.
  - A handshake in the redirect cycle has no effect beyond the flush.
  - No request is issued in the redirect cycle.
- **Reset values**
  - `pc = RESET_PC`; all pointers 0; `discard_cnt = 0`; all filled bits 0.
  - Outputs during reset: `i_req = 0`, `i_address = RESET_PC`, `instr_valid = 0`.

## Timing
- Request→instruction: a ROM response in cycle N is registered into the queue and `instr_valid` rises in cycle N+1. With a 1-cycle ROM, request in cycle R gives `instr_valid` in R+2.
- Throughput: one instruction per cycle sustained when ROM latency + 1 ≤ DEPTH.
- Redirect in cycle N: first request to the target in N+1; earliest `instr_valid` for it in N+3 with a 1-cycle ROM.
- Full: `alloc_ptr - rd_ptr == DEPTH` deasserts `i_req` combinationally. A pop in the same cycle does not re-enable issue until the next cycle.
- Stale responses are dropped in arrival order before any post-redirect data is accepted.
- Back-to-back redirects: `discard_cnt` accumulates and saturates at most DEPTH by construction.

## Structure
- `dlx_pkg` holds:
  - `XLEN`, and `INSTR_BYTES = 4` as the PC increment.
  - `fetch_slot_t` struct {pc, data, filled}.
  - Shared `clog2`-derived pointer width helpers.
- Sub-module `dlx_fetch_slot_queue` contains the slot array plus the alloc/fill/read pointers and flush. The top keeps `pc`, the issue logic, the redirect mux and `discard_cnt`.

## Test plan
- Reset with `RESET_PC = 0x100` and a 1-cycle ROM, `instr_ready = 1`: requests go to 0x100, 0x104, 0x108…; `instr_pc` presents 0x100 two cycles after the first request, then one per cycle.
- `instr_ready = 0` with DEPTH = 4: exactly 4 requests issue, `i_req` stays low, `instr_valid` is held at 0x100. After release, 4 pops follow in order and issue resumes.
- 3-cycle ROM with 3 requests in flight, then `pc_cmd_EX = 1` to 0x400: the 3 stale responses are dropped and the first delivered instruction has `instr_pc = 0x400`.
- `pc_cmd_ID` to 0x200 and `pc_cmd_EX` to 0x300 in the same cycle: the next request is at 0x300.
- Redirects to 0x200 and then 0x300 on consecutive cycles with a 2-cycle ROM: no stale data is delivered and the first `instr_pc` is 0x300.
- `reset` asserted asynchronously mid-burst: `i_req` and `instr_valid` drop immediately; after release fetch restarts at `RESET_PC` with `discard_cnt = 0`.
